// File: rtl/flappy_pkg.sv
// Shared game types and constants for the pipe scheduler and its helpers.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

  localparam logic [9:0] INIT_X [4] = '{10'd400, 10'd570, 10'd740, 10'd910};
  localparam logic [9:0] INIT_Y [4] = '{10'd160, 10'd200, 10'd240, 10'd280};

  localparam logic [9:0]  GAP_HALF    = 10'd75;
  localparam logic [9:0]  PIPE_HW     = 10'd25;
  localparam logic [9:0]  GAP_BASE    = 10'd100;
  localparam logic [7:0]  LFSR_SEED   = 8'hA5;
  localparam logic [23:0] COLOUR_LIVE = 24'h00C000;
  localparam logic [23:0] COLOUR_DEAD = 24'hC00000;

  // Colour follows the state the FSM is entering so it stays aligned with game_state.
  function automatic logic [23:0] state_colour(input game_state_t st);
    logic [23:0] c;
    case (st)
      ST_DEAD: c = COLOUR_DEAD;
      default: c = COLOUR_LIVE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used for pipe gap heights.
module lfsr8
  import flappy_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  output logic [7:0] q
);

  logic [7:0] q_r;

  // Shift register advancing every clock regardless of game state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_r <= LFSR_SEED;
    end else begin
      q_r <= {q_r[6:0], q_r[7] ^ q_r[5] ^ q_r[4] ^ q_r[3]};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_scheduler.sv
// Four-pipe scroller for a flappy-style game: game FSM, pipe motion/respawn,
// pass scoring and pipe colour.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int unsigned SPEED   = 2,
  parameter int unsigned SPACING = 170,
  parameter int unsigned BIRD_X  = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collide,
  output logic [9:0] Pipe1X,
  output logic [9:0] Pipe2X,
  output logic [9:0] Pipe3X,
  output logic [9:0] Pipe4X,
  output logic [9:0] Pipe1Y,
  output logic [9:0] Pipe2Y,
  output logic [9:0] Pipe3Y,
  output logic [9:0] Pipe4Y,
  output logic [7:0] PipeR,
  output logic [7:0] PipeG,
  output logic [7:0] PipeB,
  output logic [1:0] game_state,
  output logic [7:0] score
);

  localparam logic [9:0] SPEED_W  = 10'(SPEED);
  localparam logic [9:0] WRAP_ADD = 10'(4 * SPACING);
  localparam logic [9:0] BIRD_W   = 10'(BIRD_X);

  game_state_t state_r, state_nx_s;
  logic [9:0]  x_r [4];
  logic [9:0]  y_r [4];
  logic [9:0]  nx_s [4];
  logic [3:0]  wrap_s, pass_s;
  logic [7:0]  score_r;
  logic [23:0] colour_r;
  logic [7:0]  lfsr_q_s;
  logic [9:0]  gap_s;
  logic        move_s;
  logic        unused_lfsr_lsb_s;

  lfsr8 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr_q_s)
  );

  assign unused_lfsr_lsb_s = lfsr_q_s[0];
  assign gap_s = GAP_BASE + {3'b000, lfsr_q_s[7:1]};

  // Next-state logic; collide has priority over start and frame_tick in PLAY.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (start)   state_nx_s = ST_PLAY; else state_nx_s = ST_IDLE;
      ST_PLAY: if (collide) state_nx_s = ST_DEAD; else state_nx_s = ST_PLAY;
      ST_DEAD: if (start)   state_nx_s = ST_IDLE; else state_nx_s = ST_DEAD;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Per-pipe step, wrap test (done on the pre-subtraction X) and bird-pass detection.
  always_comb begin
    move_s = (state_r == ST_PLAY) && frame_tick && !collide;
    for (int i = 0; i < 4; i++) begin
      nx_s[i]   = x_r[i] - SPEED_W;
      wrap_s[i] = (x_r[i] <= (PIPE_HW + SPEED_W));
      pass_s[i] = ((x_r[i] + PIPE_HW) >= BIRD_W) && ((nx_s[i] + PIPE_HW) < BIRD_W);
    end
  end

  // Game state, pipe positions, score and colour registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      score_r  <= 8'd0;
      colour_r <= COLOUR_LIVE;
      for (int i = 0; i < 4; i++) begin
        x_r[i] <= INIT_X[i];
        y_r[i] <= INIT_Y[i];
      end
    end else begin
      state_r  <= state_nx_s;
      colour_r <= state_colour(state_nx_s);
      if ((state_r == ST_DEAD) && (state_nx_s == ST_IDLE)) begin
        for (int i = 0; i < 4; i++) begin
          x_r[i] <= INIT_X[i];
          y_r[i] <= INIT_Y[i];
        end
      end else if (move_s) begin
        for (int i = 0; i < 4; i++) begin
          if (wrap_s[i]) begin
            x_r[i] <= nx_s[i] + WRAP_ADD;
            y_r[i] <= gap_s;
          end else begin
            x_r[i] <= nx_s[i];
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          x_r[i] <= x_r[i];
          y_r[i] <= y_r[i];
        end
      end
      if ((state_r == ST_IDLE) && (state_nx_s == ST_PLAY)) begin
        score_r <= 8'd0;
      end else if (move_s && (|pass_s) && (score_r != 8'd255)) begin
        score_r <= score_r + 8'd1;
      end else begin
        score_r <= score_r;
      end
    end
  end

  assign Pipe1X = x_r[0];
  assign Pipe2X = x_r[1];
  assign Pipe3X = x_r[2];
  assign Pipe4X = x_r[3];
  assign Pipe1Y = y_r[0];
  assign Pipe2Y = y_r[1];
  assign Pipe3Y = y_r[2];
  assign Pipe4Y = y_r[3];
  assign PipeR  = colour_r[23:16];
  assign PipeG  = colour_r[15:8];
  assign PipeB  = colour_r[7:0];
  assign game_state = state_r;
  assign score  = score_r;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed self-checking bench for pipe_scheduler.
module tb_pipe_scheduler;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, start, collide;
  logic [9:0] p1x, p2x, p3x, p4x, p1y, p2y, p3y, p4y;
  logic [7:0] pr, pg, pb, score;
  logic [1:0] gs;
  int         checks = 0;
  int         errors = 0;

  pipe_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .collide(collide),
    .Pipe1X(p1x), .Pipe2X(p2x), .Pipe3X(p3x), .Pipe4X(p4x),
    .Pipe1Y(p1y), .Pipe2Y(p2y), .Pipe3Y(p3y), .Pipe4Y(p4y),
    .PipeR(pr), .PipeG(pg), .PipeB(pb), .game_state(gs), .score(score)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after a falling edge and sampled on the next falling edge.
  task automatic cyc(input logic t, input logic s, input logic c);
    frame_tick = t; start = s; collide = c;
    @(posedge Clk);
    @(negedge Clk);
    frame_tick = 1'b0; start = 1'b0; collide = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; collide = 1'b0;
    @(negedge Clk);
    cyc(1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    check("rst_state", gs, 0);
    check("rst_p1x", p1x, 400);
    check("rst_p4x", p4x, 910);
    check("rst_p1y", p1y, 160);
    check("rst_p4y", p4y, 280);
    check("rst_score", score, 0);
    check("rst_r", pr, 0);
    check("rst_g", pg, 192);
    check("rst_b", pb, 0);

    cyc(1'b1, 1'b0, 1'b0);
    check("idle_tick_p1x", p1x, 400);
    check("idle_tick_state", gs, 0);

    cyc(1'b0, 1'b1, 1'b0);
    check("start_state", gs, 1);
    check("start_p1x", p1x, 400);

    ticks(1);
    check("t1_p1x", p1x, 398);
    check("t1_p4x", p4x, 908);
    check("t1_state", gs, 1);
    check("t1_score", score, 0);

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("no_tick_hold_p1x", p1x, 398);

    ticks(151);
    check("t152_p1x", p1x, 96);
    check("t152_score", score, 0);
    ticks(1);
    check("t153_p1x", p1x, 94);
    check("t153_score", score, 1);

    ticks(35);
    check("t188_p1x", p1x, 704);
    check("t188_p2x", p2x, 194);
    check("t188_p1y_range", int'((p1y >= 10'd100) && (p1y <= 10'd227)), 1);
    check("t188_p2y", p2y, 200);

    ticks(21742 - 188);
    check("t21742_score", score, 254);
    ticks(1);
    check("t21743_score", score, 255);
    ticks(85);
    check("sat_score", score, 255);
    check("t21828_p1x", p1x, 264);

    cyc(1'b1, 1'b1, 1'b1);
    check("collide_start_state", gs, 2);
    check("collide_start_p1x", p1x, 264);
    check("collide_start_score", score, 255);
    check("dead_r", pr, 192);
    check("dead_g", pg, 0);

    cyc(1'b1, 1'b0, 1'b0);
    check("dead_tick_p1x", p1x, 264);
    check("dead_tick_state", gs, 2);

    cyc(1'b0, 1'b1, 1'b0);
    check("restart_state", gs, 0);
    check("restart_p1x", p1x, 400);
    check("restart_p1y", p1y, 160);
    check("restart_score_held", score, 255);
    check("restart_g", pg, 192);
    cyc(1'b0, 1'b1, 1'b0);
    check("replay_state", gs, 1);
    check("replay_score", score, 0);

    ticks(5);
    Reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    check("midrst_state", gs, 0);
    check("midrst_p1x", p1x, 400);
    check("midrst_p2x", p2x, 570);
    check("midrst_p3y", p3y, 240);
    check("midrst_score", score, 0);
    check("midrst_r", pr, 0);
    check("midrst_g", pg, 192);

    cyc(1'b0, 1'b1, 1'b0);
    ticks(50);
    check("t50_p1x", p1x, 300);
    cyc(1'b1, 1'b0, 1'b1);
    check("col_state", gs, 2);
    check("col_p1x", p1x, 300);
    check("col_p3x", p3x, 640);
    check("col_r", pr, 192);
    check("col_g", pg, 0);
    check("col_b", pb, 0);

    cyc(1'b0, 1'b1, 1'b0);
    check("held_start_idle", gs, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("held_start_play", gs, 1);
    check("held_start_score", score, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameters SHALL be: SPEED, default 2, pixels moved per frame; SPACING, default 170, X distance between adjacent pipes; BIRD_X, default 120, fixed bird column used for scoring.
REQ-002 Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-Clk pulse per video frame (vsync).
REQ-005 start  input  1  level; game-start/restart request.
REQ-006 collide  input  1  level; bird overlaps a pipe or the ground.
REQ-007 Pipe1X..Pipe4X  output  10 each  pipe centre column.
REQ-008 Pipe1Y..Pipe4Y  output  10 each  gap centre row; gap spans Y±75.
REQ-009 PipeR, PipeG, PipeB  output  8 each  colour shared by all four pipes.
REQ-010 game_state  output  2  IDLE=0, PLAY=1, DEAD=2.
REQ-011 score  output  8  pipes passed in the current game.

Function
REQ-012 FSM: IDLE --start--> PLAY; PLAY --collide--> DEAD; DEAD --start--> IDLE; no other transitions.
REQ-013 In IDLE all pipe X/Y SHALL hold their initial values: X = 400, 570, 740, 910; Y = 160, 200, 240, 280 (pipes 1..4).
REQ-014 Entering IDLE from DEAD SHALL reload the initial X/Y values in the transition cycle.
REQ-015 IDLE->PLAY SHALL clear score to 0 in the transition cycle.
REQ-016 In PLAY, on each frame_tick, each pipe SHALL compute nx = X - SPEED; if nx <= 25, X <= nx + 4*SPACING (680) and Y <= new random gap, else X <= nx.
REQ-017 Pipe movement outputs SHALL be registered and visible exactly one Clk after frame_tick; X/Y SHALL not change without frame_tick.
REQ-018 Random gap SHALL be 100 + lfsr[7:1] (range 100..227), taken from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) stepping every Clk in all states.
REQ-019 Two pipes respawning on the same tick SHALL receive the same LFSR sample.
REQ-020 Score SHALL increment on a frame_tick in PLAY when any pipe has old X+25 >= BIRD_X and new X+25 < BIRD_X; the increment is computed before any respawn wrap.
REQ-021 Score SHALL saturate at 255; score and X/Y SHALL hold in DEAD.
REQ-022 collide and frame_tick in the same PLAY cycle: collide wins; go to DEAD, no movement, no score change.
REQ-023 start and collide both high in PLAY SHALL go to DEAD; start is ignored in PLAY.
REQ-024 start held high: DEAD->IDLE in one cycle, IDLE->PLAY on the next; this is permitted.
REQ-025 Colour SHALL be 00/C0/00 in IDLE and PLAY, C0/00/00 in DEAD, registered with state.
REQ-026 All arithmetic SHALL be unsigned 10-bit; the <= 25 test SHALL be done before subtraction wrap, i.e. X <= 25 + SPEED.

Reset
REQ-027 Reset SHALL force: IDLE, initial X/Y, score 0, colour 00/C0/00, LFSR 8'hA5.
REQ-028 Reset SHALL override all other inputs in any state, including mid-frame_tick.

Structure
REQ-029 A shared package flappy_pkg SHALL hold the game_state enum, initial X/Y tables, gap half-height 75, pipe half-width 25 and colour constants.
REQ-030 The LFSR SHALL be a sub-module lfsr8 (Clk, Reset, q[7:0]).

Verification
REQ-031 Reset, start, one frame_tick -> Pipe1X = 398, Pipe4X = 908, game_state = PLAY, score = 0.
REQ-032 PLAY, 188 frame_ticks -> Pipe1X = 704, Pipe1Y in 100..227, Pipe2X = 194.
REQ-033 PLAY, 153 frame_ticks -> score = 1 after tick 153 (Pipe1X 96->94); score = 0 after tick 152.
REQ-034 collide and frame_tick in the same cycle at Pipe1X = 300 -> game_state = DEAD, Pipe1X stays 300, colour C0/00/00.
REQ-035 DEAD, start pulse -> IDLE with Pipe1X = 400, Pipe1Y = 160, score held; next start -> PLAY with score = 0.
REQ-036 Force score to 255, then a pass event -> score stays 255; Reset mid-PLAY -> all REQ-027 values the next cycle.
